dff_pipe_ift: RTL and testbench

- Parametrised successor of the single tainted D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with enable, valid flag and synchronous active-low reset.
- Each stage carries a TW-bit taint label, a shadow of the data for information-flow tracking (IFT).
- Labels combine by bitwise OR. Every control input that can influence a stage contributes its label.
- Used as the reference tainted-sequential primitive in IFT regression benches; DEPTH=1 is the tainted DFF with reset and enable.

---
 rtl/ift_pkg.sv | 22 ++
 rtl/ift_dff_stage.sv | 59 +++++
 rtl/dff_pipe_ift.sv | 82 ++++++++
 tb/tb_dff_pipe_ift.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ift_pkg.sv
// ift_pkg: shared definitions for the information-flow-tracking primitives.
//   TW_DEFAULT  : default taint label width
//   taint_t     : label type at the default width
//   TAINT_CLEAN : the all-clear label
//   taint_or2/3 : label combination (bitwise OR) at the default width
package ift_pkg;

  localparam int TW_DEFAULT = 32;

  typedef logic [TW_DEFAULT-1:0] taint_t;

  localparam taint_t TAINT_CLEAN = '0;

  function automatic taint_t taint_or2(input taint_t a, input taint_t b);
    return a | b;
  endfunction

  function automatic taint_t taint_or3(input taint_t a, input taint_t b, input taint_t c);
    return a | b | c;
  endfunction

endpackage

// File: rtl/ift_dff_stage.sv
// ift_dff_stage: one tainted register stage (data, valid, label).
//   clk_i     : clock, rising edge
//   rst_n_i   : synchronous active-low reset
//   rst_t_i   : label loaded on reset (clock label | reset label)
//   en_i      : advance enable
//   ctl_t_i   : combined label of every control that can steer this stage
//   d_i/v_i/t_i : upstream data, valid and label
//   d_o/v_o/t_o : registered data, valid and label
module ift_dff_stage #(
  parameter int WIDTH = 2,
  parameter int TW    = ift_pkg::TW_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [TW-1:0]    rst_t_i,
  input  logic             en_i,
  input  logic [TW-1:0]    ctl_t_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
  input  logic [TW-1:0]    t_i,
  output logic [WIDTH-1:0] d_o,
  output logic             v_o,
  output logic [TW-1:0]    t_o
);

  logic [WIDTH-1:0] d_q, d_d;
  logic             v_q, v_d;
  logic [TW-1:0]    t_q, t_d;

  // A hold is as much a decision of EN as an advance is, so the control
  // label is folded into the stored label on both paths.
  always_comb begin
    d_d = d_q;
    v_d = v_q;
    t_d = t_q | ctl_t_i;
    if (en_i) begin
      d_d = d_i;
      v_d = v_i;
      t_d = t_i | ctl_t_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      d_q <= '0;
      v_q <= 1'b0;
      t_q <= rst_t_i;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
      t_q <= t_d;
    end
  end

  assign d_o = d_q;
  assign v_o = v_q;
  assign t_o = t_q;

endmodule

// File: rtl/dff_pipe_ift.sv
// dff_pipe_ift: DEPTH-stage WIDTH-bit register pipeline with enable, valid
// flag and per-stage taint labels for information-flow tracking.
//   CLK, CLK_t        : clock and its label
//   RST_N, RST_N_t    : synchronous active-low reset and its label
//   EN, EN_t          : advance enable and its label
//   D, VLD_IN, D_t    : input word, valid qualifier, shared label
//   Q, VLD_OUT, Q_t   : last-stage word, valid and label (all registered)
//   TAINT_SEEN        : sticky flag, Q_t has been nonzero since reset
module dff_pipe_ift #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int TW    = ift_pkg::TW_DEFAULT
) (
  input  logic             CLK,
  input  logic [TW-1:0]    CLK_t,
  input  logic             RST_N,
  input  logic [TW-1:0]    RST_N_t,
  input  logic             EN,
  input  logic [TW-1:0]    EN_t,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  input  logic [TW-1:0]    D_t,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT,
  output logic [TW-1:0]    Q_t,
  output logic             TAINT_SEEN
);

  logic [TW-1:0] ctl_t;
  logic [TW-1:0] rst_t;

  assign ctl_t = CLK_t | RST_N_t | EN_t;
  assign rst_t = CLK_t | RST_N_t;

  // Index 0 is the pipeline input; index k+1 is the output of stage k.
  logic [DEPTH:0][WIDTH-1:0] chain_d;
  logic [DEPTH:0]            chain_v;
  logic [DEPTH:0][TW-1:0]    chain_t;

  assign chain_d[0] = D;
  assign chain_v[0] = VLD_IN;
  assign chain_t[0] = D_t;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ift_dff_stage #(
      .WIDTH (WIDTH),
      .TW    (TW)
    ) u_stage (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .rst_t_i (rst_t),
      .en_i    (EN),
      .ctl_t_i (ctl_t),
      .d_i     (chain_d[k]),
      .v_i     (chain_v[k]),
      .t_i     (chain_t[k]),
      .d_o     (chain_d[k+1]),
      .v_o     (chain_v[k+1]),
      .t_o     (chain_t[k+1])
    );
  end

  assign Q       = chain_d[DEPTH];
  assign VLD_OUT = chain_v[DEPTH];
  assign Q_t     = chain_t[DEPTH];

  // Sticky flag watches the registered output label, so it rises one edge
  // after Q_t first goes nonzero; reset wins over a coincident set.
  logic seen_q, seen_d;

  always_comb begin
    seen_d = seen_q | (|Q_t);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) seen_q <= 1'b0;
    else        seen_q <= seen_d;
  end

  assign TAINT_SEEN = seen_q;

endmodule

// File: tb/tb_dff_pipe_ift.sv
module tb_dff_pipe_ift;
  import ift_pkg::*;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  always #10 CLK = ~CLK;

  logic        RST_N;
  logic [31:0] CLK_t, RST_N_t, EN_t, D_t;
  logic        EN, VLD_IN;
  logic [1:0]  D;

  logic [1:0]  q3, q1;
  logic        vld3, vld1, seen3, seen1;
  logic [31:0] qt3, qt1;

  dff_pipe_ift #(.WIDTH(2), .DEPTH(3), .TW(32)) u_dut3 (
    .CLK(CLK), .CLK_t(CLK_t), .RST_N(RST_N), .RST_N_t(RST_N_t),
    .EN(EN), .EN_t(EN_t), .D(D), .VLD_IN(VLD_IN), .D_t(D_t),
    .Q(q3), .VLD_OUT(vld3), .Q_t(qt3), .TAINT_SEEN(seen3)
  );

  dff_pipe_ift #(.WIDTH(2), .DEPTH(1), .TW(32)) u_dut1 (
    .CLK(CLK), .CLK_t(CLK_t), .RST_N(RST_N), .RST_N_t(RST_N_t),
    .EN(EN), .EN_t(EN_t), .D(D), .VLD_IN(VLD_IN), .D_t(D_t),
    .Q(q1), .VLD_OUT(vld1), .Q_t(qt1), .TAINT_SEEN(seen1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: each instance is a list of words in flight, oldest last.
  // An advance inserts the new word at the front and drops the oldest; any
  // edge out of reset then ORs the control label into every word's label.
  typedef struct {
    logic [1:0]  d;
    logic        v;
    logic [31:0] t;
  } word_t;

  word_t m_words[2][$];
  logic  m_seen[2];
  int    m_depth[2] = '{3, 1};

  task automatic model_step();
    taint_t ctl;
    ctl = taint_or3(CLK_t, RST_N_t, EN_t);
    for (int m = 0; m < 2; m++) begin
      if (!RST_N) begin
        m_words[m].delete();
        for (int k = 0; k < m_depth[m]; k++)
          m_words[m].push_back('{d: 2'b00, v: 1'b0, t: taint_or2(CLK_t, RST_N_t)});
        m_seen[m] = 1'b0;
      end else begin
        if (m_words[m][m_depth[m]-1].t != TAINT_CLEAN) m_seen[m] = 1'b1;
        if (EN) begin
          m_words[m].push_front('{d: D, v: VLD_IN, t: D_t});
          void'(m_words[m].pop_back());
        end
        foreach (m_words[m][k]) m_words[m][k].t = m_words[m][k].t | ctl;
      end
    end
  endtask

  task automatic check_model();
    word_t w3, w1;
    w3 = m_words[0][2];
    w1 = m_words[1][0];
    check_eq("m3_q",    {30'd0, q3},    {30'd0, w3.d});
    check_eq("m3_vld",  {31'd0, vld3},  {31'd0, w3.v});
    check_eq("m3_qt",   qt3,            w3.t);
    check_eq("m3_seen", {31'd0, seen3}, {31'd0, m_seen[0]});
    check_eq("m1_q",    {30'd0, q1},    {30'd0, w1.d});
    check_eq("m1_vld",  {31'd0, vld1},  {31'd0, w1.v});
    check_eq("m1_qt",   qt1,            w1.t);
    check_eq("m1_seen", {31'd0, seen1}, {31'd0, m_seen[1]});
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: apply inputs, take one rising edge, update the
  // model, then compare at the next falling edge.
  task automatic cyc(input logic rst_n, input logic en, input logic [1:0] d,
                     input logic vld, input logic [31:0] dt, input logic [31:0] ent,
                     input logic [31:0] rstt, input logic [31:0] clkt);
    RST_N = rst_n; EN = en; D = d; VLD_IN = vld;
    D_t = dt; EN_t = ent; RST_N_t = rstt; CLK_t = clkt;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_model();
  endtask

  logic [1:0]  words[5];
  logic [1:0]  held;
  logic [1:0]  d6[3];
  logic        v6[3];

  initial begin
    RST_N = 1'b0; EN = 1'b0; D = '0; VLD_IN = 1'b0;
    D_t = '0; EN_t = '0; RST_N_t = '0; CLK_t = '0;
    @(negedge CLK);

    // 1. reset and clean flow
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_q",    {30'd0, q3},    32'd0);
    check_eq("rst_vld",  {31'd0, vld3},  32'd0);
    check_eq("rst_qt",   qt3,            32'd0);
    check_eq("rst_seen", {31'd0, seen3}, 32'd0);
    words = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, words[i], 1, 0, 0, 0, 0);
      if (i >= 2) check_eq("p1_q", {30'd0, q3}, {30'd0, words[i-2]});
      check_eq("p1_qt", qt3, 32'd0);
    end
    check_eq("p1_seen", {31'd0, seen3}, 32'd0);

    // 2. data taint propagation
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, (i == 0) ? 2'b10 : 2'($urandom_range(0, 3)), 1,
          (i == 0) ? 32'h1 : 32'h0, 0, 0, 0);
      if (i == 1) check_eq("p2_qt_before", qt3, 32'h0);
      if (i == 2) begin
        check_eq("p2_q",  {30'd0, q3}, 32'd2);
        check_eq("p2_qt", qt3, 32'h1);
        check_eq("p2_seen_lag", {31'd0, seen3}, 32'd0);
      end
      if (i == 3) begin
        check_eq("p2_qt_after", qt3, 32'h0);
        check_eq("p2_seen", {31'd0, seen3}, 32'd1);
      end
    end

    // 3. enable stall with label accumulation
    for (int i = 0; i < 3; i++) cyc(1, 1, 2'($urandom_range(0, 3)), 1, 0, 0, 0, 0);
    held = q3;
    for (int j = 0; j < 4; j++) begin
      cyc(1, 0, 2'($urandom_range(0, 3)), 1, 0, (j == 1) ? 32'h4 : 32'h0, 0, 0);
      check_eq("p3_hold", {30'd0, q3}, {30'd0, held});
      if (j >= 1) check_eq("p3_qt_stall", qt3, 32'h4);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 2'($urandom_range(0, 3)), 1, 0, 0, 0, 0);
      check_eq("p3_qt_drain", qt3, (i < 2) ? 32'h4 : 32'h0);
    end

    // 4. clock and reset taint
    cyc(0, 1, 0, 0, 0, 0, 32'h10, 32'h8);
    check_eq("p4_qt_rst", qt3, 32'h18);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 2'($urandom_range(0, 3)), 1, 0, 0, 0, 32'h8);
      check_eq("p4_qt", qt3, (i < 2) ? 32'h18 : 32'h8);
    end

    // 5. reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, 1, 2'($urandom_range(1, 3)), 1, 32'h2, 0, 0, 0);
    cyc(0, 1, 2'b11, 1, 32'h2, 0, 0, 0);
    check_eq("p5_q",    {30'd0, q3},    32'd0);
    check_eq("p5_vld",  {31'd0, vld3},  32'd0);
    check_eq("p5_qt",   qt3,            32'd0);
    check_eq("p5_seen", {31'd0, seen3}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("p5_discard", {31'd0, vld3}, 32'd0);

    // 6. bubbles through the single-stage instance
    d6 = '{2'b11, 2'b00, 2'b01};
    v6 = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, d6[i], v6[i], 0, 0, 0, 0);
      check_eq("p6_q",   {30'd0, q1},   {30'd0, d6[i]});
      check_eq("p6_vld", {31'd0, vld1}, {31'd0, v6[i]});
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) != 0),
          ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
          ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
          ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
          ($urandom_range(0, 31) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
